// File: rtl/vga_arb_pkg.sv
// Shared widths, defaults and state encoding for the VGA text-buffer write arbiter.
package vga_arb_pkg;

  localparam int unsigned ADDR_W           = 14;
  localparam int unsigned DATA_W           = 8;
  localparam int unsigned SCREEN_CELLS_DEF = 4800;
  localparam logic [DATA_W-1:0] CLEAR_CHAR_DEF = 8'h20;

  typedef enum logic {
    ARB,
    CLEAR
  } state_e;

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Bundled per-requester write request bus; requester i occupies slice i of each vector.
interface vga_write_arbiter_if
  import vga_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/vga_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr, wrapping at NREQ.
module rr_arbiter #(
  parameter int unsigned NREQ = 2,
  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant
);

  logic             found;
  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W + 1)'(k);
      if (sum >= (PTR_W + 1)'(NREQ)) begin
        sum = sum - (PTR_W + 1)'(NREQ);
      end
      idx = sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Single-port display buffer write arbiter: round-robin requesters plus a full-screen clear sweep.
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int unsigned       NREQ         = 2,
  parameter int unsigned       SCREEN_CELLS = SCREEN_CELLS_DEF,
  parameter logic [DATA_W-1:0] CLEAR_CHAR   = CLEAR_CHAR_DEF
) (
  input  logic                clk48,
  input  logic                rst,
  vga_write_arbiter_if.slave  bus,
  input  logic                clear_start,
  output logic                clear_busy,
  output logic                clear_done,
  output logic [ADDR_W-1:0]   vga_waddr,
  output logic [DATA_W-1:0]   vga_wdata,
  output logic                vga_wr_en
);

  localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [NREQ-1:0]   grant;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (grant)
  );

  // A same-cycle clear_start pre-empts every requester.
  assign bus.req_ready = (state_q == ARB && !clear_start && !rst) ? grant : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wr_en_d = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i]) begin
              wr_en_d = 1'b1;
              waddr_d = bus.req_addr[i*ADDR_W +: ADDR_W];
              wdata_d = bus.req_data[i*DATA_W +: DATA_W];
              ptr_d   = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
          end
        end
      end
      CLEAR: begin
        wr_en_d = 1'b1;
        waddr_d = cnt_q;
        wdata_d = CLEAR_CHAR;
        busy_d  = 1'b1;
        // Busy stays high through the final write; done coincides with it.
        if (cnt_q == ADDR_W'(SCREEN_CELLS - 1)) begin
          state_d = ARB;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wr_en_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wr_en_q <= wr_en_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign vga_wr_en  = wr_en_q;
  assign vga_waddr  = waddr_q;
  assign vga_wdata  = wdata_q;
  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule
